// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle between the ALU and seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, start/done handshake.
// Define DIV_SIGNED_EN to build two's-complement support (sign handling, MIN/-1 overflow).
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             dbzo_q, dbzo_d;
  logic             ovfo_q, ovfo_d;

  logic             a_neg, b_neg, ovf_case;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] qres, rres;
  logic [WIDTH:0]   shifted, trial;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    a_neg    = bus.signed_op & bus.dividend[WIDTH-1];
    b_neg    = bus.signed_op & bus.divisor[WIDTH-1];
    a_mag    = a_neg ? -bus.dividend : bus.dividend;
    b_mag    = b_neg ? -bus.divisor  : bus.divisor;
    ovf_case = bus.signed_op && (bus.dividend == MIN) && (&bus.divisor);
    qres     = negq_q ? -quot_q : quot_q;
    rres     = negr_q ? -rem_q  : rem_q;
  end
`else
  logic unused_sign;
  assign unused_sign = ^{bus.signed_op, negq_q, negr_q};

  always_comb begin
    a_neg    = 1'b0;
    b_neg    = 1'b0;
    a_mag    = bus.dividend;
    b_mag    = bus.divisor;
    ovf_case = 1'b0;
    qres     = quot_q;
    rres     = rem_q;
  end
`endif

  // Partial remainder gains the next dividend bit; bit WIDTH of trial is its sign.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbzo_d  = dbzo_q;
    ovfo_d  = ovfo_q;

    unique case (state_q)
      IDLE: begin
        // busy/done lag the state by one cycle, so a start in the done cycle is refused here
        if (bus.start && !done_q) begin
          quot_d  = a_mag;
          dvsr_d  = b_mag;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = CALC;
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            dbz_d   = 1'b1;
            state_d = FINISH;
          end else if (ovf_case) begin
            quot_d  = bus.dividend;
            rem_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            ovf_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      CALC: begin
        quot_d = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH: begin
        qout_d  = qres;
        rout_d  = rres;
        dbzo_d  = dbz_q;
        ovfo_d  = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbzo_q  <= 1'b0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbzo_q  <= dbzo_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = qout_q;
  assign bus.remainder   = rout_q;
  assign bus.div_by_zero = dbzo_q;
  assign bus.overflow    = ovfo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes model results, a negedge monitor checks them on done.
module tb_seq_divider;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  localparam logic [W-1:0] ALL1 = 32'hFFFF_FFFF;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           e0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 1;
    e.e0  = 0;
    if (b == 0) begin
      e.q = ALL1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (sop && SIGNED_EN && a == MIN && b == ALL1) begin
      e.q = MIN; e.r = '0; e.ovf = 1'b1; e.lat = 1;
    end else if (sop && SIGNED_EN) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: actual=done with no request outstanding expected=no done (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
          chk("overflow", W'(bus.overflow), W'(e.ovf));
          chk("latency", W'(cyc - e.e0), W'(e.lat));
          chk("busy_cycles", W'(busy_cnt), W'(e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    while ((bus.busy || bus.done || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual=still busy after %0d cycles expected=idle", n);
      exp_q.delete();
    end
    e = model(sop, a, b);
    e.e0 = cyc + 1;
    bus.start     = 1'b1;
    bus.signed_op = sop;
    bus.dividend  = a;
    bus.divisor   = b;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  task automatic pulse_start();
    bus.start     = 1'b1;
    bus.signed_op = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called one cycle after the accept: stray starts at cycles 5 and 20 of the operation.
  task automatic interfere();
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (14) @(negedge clk);
    pulse_start();
  endtask

  task automatic start_in_done_cycle();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=no done after %0d cycles expected=done", n);
    end else begin
      pulse_start();
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit           sop;
    int           n;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    #12;
    chk("reset_busy", W'(bus.busy), '0);
    chk("reset_done", W'(bus.done), '0);
    chk("reset_quotient", bus.quotient, '0);
    chk("reset_remainder", bus.remainder, '0);
    chk("reset_dbz", W'(bus.div_by_zero), '0);
    chk("reset_ovf", W'(bus.overflow), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'd100, 32'd7);
    start_in_done_cycle();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    issue(1'b0, 32'd1234, 32'd0);
    start_in_done_cycle();
    issue(1'b0, 32'd1000, 32'd10);
    issue(1'b1, MIN, ALL1);
    issue(1'b0, MIN, ALL1);
    issue(1'b1, 32'd12345, 32'd0);
    issue(1'b0, 32'hDEAD_BEEF, 32'd977);
    interfere();
    issue(1'b1, 32'h8000_0001, 32'hFFFF_FFF0);
    interfere();

    // Reset in the middle of a divide: outputs clear at once, no done follows.
    issue(1'b0, $urandom, 32'd3);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", W'(bus.busy), '0);
    chk("midreset_done", W'(bus.done), '0);
    chk("midreset_quotient", bus.quotient, '0);
    chk("midreset_remainder", bus.remainder, '0);
    chk("midreset_dbz", W'(bus.div_by_zero), '0);
    chk("midreset_ovf", W'(bus.overflow), '0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, ALL1, 32'd16);

    for (int i = 0; i < 40; i++) begin
      sop = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MIN; b = ALL1; end
        2: b = $urandom_range(1, 15);
        3: b = ALL1 - $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(sop, a, b);
      if (i % 7 == 3 && exp_q.size() != 0 && exp_q[0].lat > 20) interfere();
      if (i % 5 == 1) start_in_done_cycle();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual=%0d results outstanding expected=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
